// File: rtl/key_load_ctrl_if.sv
// Serial key-bit handshake between a key source and key_load_ctrl.
// The source drives key_bit/key_bit_valid. The controller answers with key_bit_ready.
interface key_load_ctrl_if;
  logic key_bit;
  logic key_bit_valid;
  logic key_bit_ready;

  modport master (output key_bit, output key_bit_valid, input key_bit_ready);
  modport slave  (input key_bit, input key_bit_valid, output key_bit_ready);
endinterface

// File: rtl/key_load_ctrl.sv
// Loads an unlock key MSB first, checks its even parity, and presents it to a locked netlist.
// The key bus stays all-zero until a complete, parity-correct key is armed.
module key_load_ctrl #(
  parameter int KEY_W   = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               zeroize,
  key_load_ctrl_if.slave     kif,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_armed,
  output logic               key_err,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PARITY = 3'd2,
    ARMED  = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [KEY_W-1:0]  shreg;
  logic [CNT_W-1:0]  bcnt;
  logic [CNT_W-1:0]  tcnt;
  logic              xfer;
  logic              timed_out;
  logic              parity_ok;

  assign kif.key_bit_ready = (state == LOAD) || (state == PARITY);
  assign busy              = (state == LOAD) || (state == PARITY);
  assign key_armed         = (state == ARMED);
  assign key_err           = (state == ERROR);

  // Timeout wins over a transfer landing on the same edge, so a stalled load never arms.
  always_comb begin
    state_n   = state;
    xfer      = kif.key_bit_valid && kif.key_bit_ready;
    timed_out = busy && (tcnt == CNT_W'(TIMEOUT));
    parity_ok = ~(^{shreg, kif.key_bit});
    if (zeroize) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) state_n = LOAD;
        end
        LOAD: begin
          if (timed_out)                                state_n = ERROR;
          else if (xfer && (bcnt == CNT_W'(KEY_W - 1))) state_n = PARITY;
        end
        PARITY: begin
          if (timed_out) state_n = ERROR;
          else if (xfer) state_n = parity_ok ? ARMED : ERROR;
        end
        ARMED, ERROR: begin
          if (start) state_n = LOAD;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bcnt    <= '0;
      tcnt    <= '0;
      key_out <= '0;
    end else begin
      state <= state_n;
      if (zeroize) begin
        shreg   <= '0;
        bcnt    <= '0;
        tcnt    <= '0;
        key_out <= '0;
      end else begin
        case (state)
          IDLE, ARMED, ERROR: begin
            if (start) begin
              shreg   <= '0;
              bcnt    <= '0;
              tcnt    <= '0;
              key_out <= '0;
            end
          end
          LOAD: begin
            if (xfer) begin
              shreg <= {shreg[KEY_W-2:0], kif.key_bit};
              bcnt  <= bcnt + CNT_W'(1);
              tcnt  <= '0;
            end else begin
              tcnt  <= tcnt + CNT_W'(1);
            end
          end
          PARITY: begin
            if (xfer) tcnt <= '0;
            else      tcnt <= tcnt + CNT_W'(1);
            if (state_n == ARMED) key_out <= shreg;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl with a parity-rule reference model and randomized loads.
module tb_key_load_ctrl;

  localparam int KEY_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             zeroize;
  logic [KEY_W-1:0] key_out;
  logic             key_armed;
  logic             key_err;
  logic             busy;

  key_load_ctrl_if kif ();

  key_load_ctrl #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .zeroize   (zeroize),
    .kif       (kif),
    .key_out   (key_out),
    .key_armed (key_armed),
    .key_err   (key_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int rdy_total = 0;
  int inv_viol = 0;

  // Watches the key-bus invariant and that ready only shows while a load is in progress.
  always @(negedge clk) begin
    if (kif.key_bit_ready === 1'b1) rdy_total++;
    if (rst === 1'b0) begin
      if (((key_out !== '0) && (key_armed !== 1'b1)) || (kif.key_bit_ready !== busy)) begin
        inv_viol++;
        if (inv_viol < 5)
          $display("[TB] invariant violated at %0t: key_out=%h armed=%b ready=%b busy=%b",
                   $time, key_out, key_armed, kif.key_bit_ready, busy);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap, input logic st);
    int n;
    kif.key_bit_valid = 1'b0;
    repeat (gap) tick();
    kif.key_bit       = b;
    kif.key_bit_valid = 1'b1;
    start             = st;
    n = 0;
    while (kif.key_bit_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (kif.key_bit_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_bit: ready got %b after %0d cycles, expected 1", kif.key_bit_ready, n);
    end else begin
      tick();
    end
    kif.key_bit_valid = 1'b0;
    start             = 1'b0;
  endtask

  task automatic load_bits(input logic [KEY_W-1:0] k, input logic par, input int gap, input int start_at);
    for (int i = 0; i < KEY_W; i++) send_bit(k[KEY_W-1-i], gap, (i == start_at));
    send_bit(par, gap, 1'b0);
  endtask

  // Expected {key_out, key_armed, key_err, busy} after a complete load, from the parity rule.
  function automatic logic [KEY_W+2:0] model_result(input logic [KEY_W-1:0] k, input logic par);
    logic good;
    good = ((^k) ^ par) == 1'b0;
    return good ? {k, 3'b100} : {{KEY_W{1'b0}}, 3'b010};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; zeroize = 1'b0;
    kif.key_bit = 1'b0; kif.key_bit_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tests++;
    if ({key_out, key_armed, key_err, busy, kif.key_bit_ready} !== '0) begin
      fails++;
      $display("[TB] FAIL reset: got out=%h armed=%b err=%b busy=%b ready=%b, expected all 0",
               key_out, key_armed, key_err, busy, kif.key_bit_ready);
    end
  endtask

  task automatic test_good_load();
    int r0;
    logic [KEY_W+2:0] exp;
    r0 = rdy_total;
    pulse_start();
    load_bits(8'hA5, 1'b0, 0, -1);
    exp = model_result(8'hA5, 1'b0);
    tests++;
    if ({key_out, key_armed, key_err, busy} !== exp) begin
      fails++;
      $display("[TB] FAIL good_load: got %h, expected %h", {key_out, key_armed, key_err, busy}, exp);
    end
    repeat (3) tick();
    tests++;
    if ((rdy_total - r0) != KEY_W + 1) begin
      fails++;
      $display("[TB] FAIL good_load_ready_cycles: got %0d, expected %0d", rdy_total - r0, KEY_W + 1);
    end
  endtask

  task automatic test_bad_parity();
    pulse_start();
    load_bits(8'h07, 1'b0, 0, -1);
    tests++;
    if ({key_out, key_armed, key_err, busy} !== model_result(8'h07, 1'b0)) begin
      fails++;
      $display("[TB] FAIL bad_parity: got %h, expected %h",
               {key_out, key_armed, key_err, busy}, model_result(8'h07, 1'b0));
    end
    pulse_start();
    tests++;
    if ({key_out, key_armed, key_err, busy} !== {{KEY_W{1'b0}}, 3'b001}) begin
      fails++;
      $display("[TB] FAIL bad_parity_restart: got %h, expected %h",
               {key_out, key_armed, key_err, busy}, {{KEY_W{1'b0}}, 3'b001});
    end
    load_bits(8'h07, 1'b1, 0, -1);
    tests++;
    if ({key_out, key_armed, key_err, busy} !== model_result(8'h07, 1'b1)) begin
      fails++;
      $display("[TB] FAIL bad_parity_retry: got %h, expected %h",
               {key_out, key_armed, key_err, busy}, model_result(8'h07, 1'b1));
    end
  endtask

  task automatic test_throttled();
    pulse_start();
    load_bits(8'h3C, 1'b0, 3, -1);
    tests++;
    if ({key_out, key_armed, key_err, busy} !== model_result(8'h3C, 1'b0)) begin
      fails++;
      $display("[TB] FAIL throttled: got %h, expected %h",
               {key_out, key_armed, key_err, busy}, model_result(8'h3C, 1'b0));
    end
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0);
    repeat (TIMEOUT + 4) tick();
    tests++;
    if ({key_out, key_armed, key_err, busy} !== {{KEY_W{1'b0}}, 3'b010}) begin
      fails++;
      $display("[TB] FAIL timeout: got %h, expected %h",
               {key_out, key_armed, key_err, busy}, {{KEY_W{1'b0}}, 3'b010});
    end
  endtask

  task automatic test_reload();
    pulse_start();
    load_bits(8'hA5, 1'b0, 0, -1);
    pulse_start();
    tests++;
    if ({key_out, key_armed, key_err, busy} !== {{KEY_W{1'b0}}, 3'b001}) begin
      fails++;
      $display("[TB] FAIL reload_clear: got %h, expected %h",
               {key_out, key_armed, key_err, busy}, {{KEY_W{1'b0}}, 3'b001});
    end
    load_bits(8'h5A, 1'b0, 0, 3);
    tests++;
    if ({key_out, key_armed, key_err, busy} !== model_result(8'h5A, 1'b0)) begin
      fails++;
      $display("[TB] FAIL reload: got %h, expected %h",
               {key_out, key_armed, key_err, busy}, model_result(8'h5A, 1'b0));
    end
  endtask

  task automatic test_zeroize_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0);
    kif.key_bit = 1'b1; kif.key_bit_valid = 1'b1; zeroize = 1'b1;
    tick();
    zeroize = 1'b0; kif.key_bit_valid = 1'b0;
    tests++;
    if ({key_out, key_armed, key_err, busy, kif.key_bit_ready} !== '0) begin
      fails++;
      $display("[TB] FAIL zeroize: got out=%h armed=%b err=%b busy=%b ready=%b, expected all 0",
               key_out, key_armed, key_err, busy, kif.key_bit_ready);
    end
    pulse_start();
    load_bits(8'hFF, 1'b0, 0, -1);
    tests++;
    if ({key_out, key_armed, key_err, busy} !== model_result(8'hFF, 1'b0)) begin
      fails++;
      $display("[TB] FAIL zeroize_reload: got %h, expected %h",
               {key_out, key_armed, key_err, busy}, model_result(8'hFF, 1'b0));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({key_out, key_armed, key_err, busy} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_armed: got %h, expected 0", {key_out, key_armed, key_err, busy});
    end
  endtask

  task automatic test_random();
    logic [KEY_W-1:0] k;
    logic             par;
    int               gap;
    for (int n = 0; n < 12; n++) begin
      k   = KEY_W'($urandom);
      par = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 5);
      pulse_start();
      load_bits(k, par, gap, -1);
      tests++;
      if ({key_out, key_armed, key_err, busy} !== model_result(k, par)) begin
        fails++;
        $display("[TB] FAIL random_%0d key=%h par=%b gap=%0d: got %h, expected %h",
                 n, k, par, gap, {key_out, key_armed, key_err, busy}, model_result(k, par));
      end
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (inv_viol !== 0) begin
      fails++;
      $display("[TB] FAIL invariants: got %0d violations, expected 0", inv_viol);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_parity();
    test_throttled();
    test_reload();
    test_zeroize_reset();
    test_random();
    repeat (2) tick();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_load_ctrl.md
Name: key_load_ctrl

Overview:
- Key-delivery side of the logic-locked netlists: receives an unlock key as a serial bit stream and checks its even parity.
- Presents the key in parallel on the key inputs of a locked combinational block.
- Until a complete key with correct parity has arrived, the key bus is held at all-zero, which keeps the locked block in its locked state.
- Includes a per-bit timeout and a zeroize input.

Parameters:
KEY_W, 8, key width in bits (2..64)
TIMEOUT, 16, max cycles allowed between accepted bits while loading (≥2)
CNT_W, 7, width of bit and timeout counters; must satisfy 2^CNT_W > max(KEY_W, TIMEOUT)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a new key load (pulse)
zeroize  input  1  clear key and return to IDLE
key_bit  input  1  serial key/parity data
key_bit_valid  input  1  key_bit is valid this cycle
key_bit_ready  output  1  block accepts key_bit this cycle
key_out  output  KEY_W  parallel key to locked netlist
key_armed  output  1  key_out holds a verified key
key_err  output  1  last load failed (parity or timeout)
busy  output  1  load in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset state: state=IDLE; key_out=0; key_armed=0; key_err=0; busy=0; key_bit_ready=0; shift register, bit counter and timeout counter all 0.
- Transfer rule: a bit is transferred on a rising edge where key_bit_valid && key_bit_ready. key_bit_ready is a pure function of state: 1 in LOAD and PARITY, 0 elsewhere. It never depends on key_bit_valid.
- Bit order: MSB first. The first key bit accepted lands in key_out[KEY_W-1] once armed. KEY_W key bits are followed by one parity bit. Parity is good when the XOR of all KEY_W+1 bits is 0.
- IDLE:
  - start=1 -> LOAD; clear shift register, counters and key_err.
- LOAD:
  - busy=1; key_out=0; key_armed=0.
  - Each transfer shifts the bit in and increments the bit counter.
  - The transfer that brings the count to KEY_W -> PARITY.
- PARITY:
  - busy=1.
  - On transfer, compute the parity check.
  - Good: -> ARMED; on the same edge key_out <= shift register and key_armed <= 1.
  - Bad: -> ERROR; key_err <= 1; key_out stays 0.
  - Result is visible in the cycle after the parity transfer.
- ARMED:
  - key_out held and stable; key_armed=1.
  - start=1 -> LOAD; on that edge key_out <= 0 and key_armed <= 0.
- ERROR:
  - key_err=1; key_out=0.
  - start=1 -> LOAD; key_err cleared on that edge.
- Timeout:
  - In LOAD and PARITY, the timeout counter resets on every transfer and increments on every other cycle.
  - When it reaches TIMEOUT, go to ERROR with key_err=1 on the next edge. The partial key is discarded and never appears on key_out.
- start while in LOAD or PARITY is ignored; the load continues.
- zeroize:
  - Takes effect in any state.
  - Next edge: state=IDLE; key_out=0; key_armed=0; key_err=0; shift register cleared.
  - Has priority over start and over a simultaneous transfer; that bit is dropped.
- rst:
  - Overrides everything, including mid-load; outputs return to their reset values on the next edge.
- Invariant: key_out is nonzero only while key_armed=1.
- busy = 1 exactly in LOAD and PARITY.

Test Plan:
- Good load: KEY_W=8. Pulse start, then send bits of 0xA5 MSB first, then parity 0, all back-to-back with valid=1. Required: key_bit_ready high for 9 cycles; one cycle after the parity transfer, key_out=0xA5, key_armed=1, busy=0, key_err=0.
- Bad parity: send 0x07 with parity 0. Required: key_err=1, key_armed=0, key_out=0x00, state ERROR. Then pulse start and send 0x07 with parity 1. Required: key_out=0x07, key_armed=1, key_err=0.
- Throttled input: 0x3C with parity 0, with key_bit_valid deasserted 3 cycles between each bit (gap below TIMEOUT=16). Required: key_out=0x3C and armed. A gap of 16 idle cycles after the 4th bit instead gives key_err=1 and key_out=0.
- Reload while armed: armed with 0xA5, pulse start. Required: key_out=0x00 and key_armed=0 the next cycle; a new load of 0x5A with parity 0 then arms with 0x5A. A start pulse during that load has no effect.
- Zeroize/reset mid-operation: assert zeroize on the same edge as the 5th key bit transfer. Required: IDLE next cycle, all outputs 0, and a subsequent full load of 0xFF with parity 0 arms correctly. Repeat with rst while armed: key_out=0 and key_armed=0 after one edge.
- Invariant check: across all scenarios, assert key_out==0 whenever key_armed==0, and assert key_bit_ready is never 1 outside LOAD and PARITY.
